// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : control_fsm
// Description : Multicycle datapath control unit. It accepts one instruction
//               per run handshake and sequences the register/ALU controls.
// Revision    : 1.0 - initial release
// ============================================================================
module control_fsm #(
    parameter int INSTR_W   = 16,
    parameter int NUM_REGS  = 8,
    parameter int REG_SEL_W = 3,
    parameter int OP_W      = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic [INSTR_W-1:0]  inn,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          opSelect,
    output logic                immSelect,
    output logic [INSTR_W-1:0]  immData,
    output logic                regRSelect,
    output logic                regAEnable,
    output logic                regREnable,
    output logic [NUM_REGS-1:0] regSelect,
    output logic [NUM_REGS-1:0] regEnable
);

    localparam int c_IR_W = 2*REG_SEL_W + OP_W;

    localparam logic [3:0] c_IDLE      = 4'd0;
    localparam logic [3:0] c_DECODE    = 4'd1;
    localparam logic [3:0] c_LOAD_A    = 4'd2;
    localparam logic [3:0] c_EXEC      = 4'd3;
    localparam logic [3:0] c_WRITE     = 4'd4;
    localparam logic [3:0] c_MOVE      = 4'd5;
    localparam logic [3:0] c_IMM_WAIT  = 4'd6;
    localparam logic [3:0] c_IMM_WRITE = 4'd7;
    localparam logic [3:0] c_DONE      = 4'd8;

    localparam logic [OP_W-1:0]      c_OP_MV   = OP_W'(3);
    localparam logic [OP_W-1:0]      c_OP_MVI  = OP_W'(6);
    localparam logic [REG_SEL_W:0]   c_NREGS   = (REG_SEL_W+1)'(NUM_REGS);
    localparam logic [NUM_REGS-1:0]  c_ONE     = NUM_REGS'(1);

    logic [3:0]           r_state;
    logic [3:0]           w_next;
    logic [c_IR_W-1:0]    r_ir;
    logic [INSTR_W-1:0]   r_imm;

    logic [OP_W-1:0]      w_opc;
    logic [REG_SEL_W-1:0] w_rx;
    logic [REG_SEL_W-1:0] w_ry;
    logic                 w_is_mv;
    logic                 w_is_mvi;
    logic                 w_illegal;
    logic [NUM_REGS-1:0]  w_rx_oh;
    logic [NUM_REGS-1:0]  w_ry_oh;

    // Only the opcode/rx/ry fields of the instruction are kept.
    assign w_opc    = r_ir[c_IR_W-1:2*REG_SEL_W];
    assign w_rx     = r_ir[2*REG_SEL_W-1:REG_SEL_W];
    assign w_ry     = r_ir[REG_SEL_W-1:0];
    assign w_is_mv  = (w_opc == c_OP_MV);
    assign w_is_mvi = (w_opc == c_OP_MVI);
    assign w_rx_oh  = c_ONE << w_rx;
    assign w_ry_oh  = c_ONE << w_ry;

    // MVI never reads ry, so an out-of-range ry is harmless there.
    assign w_illegal = ({1'b0, w_rx} >= c_NREGS) ||
                       (({1'b0, w_ry} >= c_NREGS) && !w_is_mvi);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:      if (run) w_next = c_DECODE;
            c_DECODE: begin
                if (w_illegal)     w_next = c_DONE;
                else if (w_is_mvi) w_next = c_IMM_WAIT;
                else if (w_is_mv)  w_next = c_MOVE;
                else               w_next = c_LOAD_A;
            end
            c_LOAD_A:    w_next = c_EXEC;
            c_EXEC:      w_next = c_WRITE;
            c_WRITE:     w_next = c_DONE;
            c_MOVE:      w_next = c_DONE;
            c_IMM_WAIT:  if (run) w_next = c_IMM_WRITE;
            c_IMM_WRITE: w_next = c_DONE;
            c_DONE:      w_next = c_IDLE;
            default:     w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_ir    <= '0;
            r_imm   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_IDLE && run)
                r_ir <= inn[c_IR_W-1:0];
            if (r_state == c_IMM_WAIT && run)
                r_imm <= inn;
        end
    end

    // ir only changes on the IDLE->DECODE edge, so this holds until the next DECODE.
    always_comb begin
        opSelect = 2'b00;
        case (w_opc)
            OP_W'(0):                     opSelect = 2'b00;
            OP_W'(1):                     opSelect = 2'b01;
            OP_W'(2):                     opSelect = 2'b10;
            OP_W'(4), OP_W'(5), OP_W'(7): opSelect = 2'b11;
            default:                      opSelect = 2'b00;
        endcase
    end

    always_comb begin
        busy       = (r_state != c_IDLE);
        done       = (r_state == c_DONE);
        err        = (r_state == c_DONE) && w_illegal;
        immData    = r_imm;
        immSelect  = 1'b0;
        regRSelect = 1'b0;
        regAEnable = 1'b0;
        regREnable = 1'b0;
        regSelect  = '0;
        regEnable  = '0;
        case (r_state)
            c_LOAD_A: begin
                regSelect  = w_rx_oh;
                regAEnable = 1'b1;
            end
            c_EXEC: begin
                regSelect  = w_ry_oh;
                regREnable = 1'b1;
            end
            c_WRITE: begin
                regRSelect = 1'b1;
                regEnable  = w_rx_oh;
            end
            c_MOVE: begin
                regSelect  = w_ry_oh;
                regEnable  = w_rx_oh;
            end
            c_IMM_WRITE: begin
                immSelect  = 1'b1;
                regEnable  = w_rx_oh;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_fsm
// Description : Self-checking bench for control_fsm (8-register and 6-register
//               instances), cycle-by-cycle scoreboard plus directed corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_fsm;

    localparam int ALU = 0;
    localparam int MV  = 1;
    localparam int MVI = 2;
    localparam int BAD = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        run, run2;
    logic [15:0] inn, inn2;

    logic        busy, done, err, immSelect, regRSelect, regAEnable, regREnable;
    logic [1:0]  opSelect;
    logic [15:0] immData;
    logic [7:0]  regSelect, regEnable;

    logic        d2_busy, d2_done, d2_err, d2_immSelect, d2_regRSelect, d2_regAEnable, d2_regREnable;
    logic [1:0]  d2_opSelect;
    logic [15:0] d2_immData;
    logic [5:0]  d2_regSelect, d2_regEnable;

    control_fsm #(.INSTR_W(16), .NUM_REGS(8), .REG_SEL_W(3), .OP_W(3)) dut (
        .clock(clock), .reset(reset), .run(run), .inn(inn),
        .busy(busy), .done(done), .err(err), .opSelect(opSelect),
        .immSelect(immSelect), .immData(immData), .regRSelect(regRSelect),
        .regAEnable(regAEnable), .regREnable(regREnable),
        .regSelect(regSelect), .regEnable(regEnable)
    );

    control_fsm #(.INSTR_W(16), .NUM_REGS(6), .REG_SEL_W(3), .OP_W(3)) dut6 (
        .clock(clock), .reset(reset), .run(run2), .inn(inn2),
        .busy(d2_busy), .done(d2_done), .err(d2_err), .opSelect(d2_opSelect),
        .immSelect(d2_immSelect), .immData(d2_immData), .regRSelect(d2_regRSelect),
        .regAEnable(d2_regAEnable), .regREnable(d2_regREnable),
        .regSelect(d2_regSelect), .regEnable(d2_regEnable)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic [1:0]  op;
        logic        immsel;
        logic [15:0] immdata;
        logic        rsel;
        logic        aen;
        logic        ren;
        logic [7:0]  rs;
        logic [7:0]  re;
    } snap_t;

    typedef struct {
        logic [15:0] inn;
        int          cls;
        logic [1:0]  op;
        int          waits;
        logic [15:0] imm;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    snap_t       q[$];
    logic [1:0]  m_op;
    logic [15:0] m_imm;
    bit          bad6_seen = 1'b0;
    bit          mon6_on   = 1'b1;
    vec_t        vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    endtask

    function automatic snap_t sample1();
        snap_t s;
        s.busy = busy;        s.done = done;         s.err = err;
        s.op = opSelect;      s.immsel = immSelect;  s.immdata = immData;
        s.rsel = regRSelect;  s.aen = regAEnable;    s.ren = regREnable;
        s.rs = regSelect;     s.re = regEnable;
        return s;
    endfunction

    function automatic snap_t base();
        snap_t s;
        s = '0;
        s.busy = 1'b1;
        s.op = m_op;
        s.immdata = m_imm;
        return s;
    endfunction

    // Expected outputs for every cycle from the accept cycle through DONE.
    task automatic push_instr(input vec_t v, output int n);
        snap_t      s;
        logic [7:0] ohx, ohy;
        ohx = 8'd1 << v.inn[5:3];
        ohy = 8'd1 << v.inn[2:0];
        s = '0; s.op = m_op; s.immdata = m_imm;
        q.push_back(s);
        m_op = v.op;
        q.push_back(base());
        n = 1;
        case (v.cls)
            ALU: begin
                s = base(); s.rs = ohx; s.aen = 1'b1; q.push_back(s);
                s = base(); s.rs = ohy; s.ren = 1'b1; q.push_back(s);
                s = base(); s.rsel = 1'b1; s.re = ohx; q.push_back(s);
                n += 3;
            end
            MV: begin
                s = base(); s.rs = ohy; s.re = ohx; q.push_back(s);
                n += 1;
            end
            MVI: begin
                repeat (v.waits + 1) q.push_back(base());
                n += v.waits + 1;
                m_imm = v.imm;
                s = base(); s.immsel = 1'b1; s.re = ohx; q.push_back(s);
                n += 1;
            end
            default: ;
        endcase
        s = base(); s.done = 1'b1; s.err = (v.cls == BAD); q.push_back(s);
        n += 1;
    endtask

    // Entered and left at posedge+1 of an IDLE cycle.
    task automatic run_vec(input vec_t v);
        int n;
        push_instr(v, n);
        run = 1'b1;
        inn = v.inn;
        @(posedge clock); #1;
        run = (v.cls == MVI) ? 1'b0 : 1'($urandom_range(0, 1));
        inn = 16'($urandom);
        for (int k = 1; k <= n; k++) begin
            @(posedge clock); #1;
            inn = 16'($urandom);
            if (v.cls == MVI && k == 1 + v.waits) begin
                run = 1'b1;
                inn = v.imm;
            end else if (v.cls != MVI && k < n) begin
                run = 1'($urandom_range(0, 1));
            end else begin
                run = 1'b0;
            end
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            snap_t e;
            e = q.pop_front();
            chk("cycle_outputs", 64'(sample1()), 64'(e));
        end
    end

    always @(negedge clock) begin
        if (mon6_on && (d2_regEnable != 6'd0 || d2_regAEnable)) bad6_seen = 1'b1;
    end

    initial begin
        reset = 1'b1; run = 1'b0; inn = '0; run2 = 1'b0; inn2 = '0;
        m_op = 2'b00; m_imm = 16'h0000;

        vecs[0] = '{16'h0015, ALU, 2'b00, 0, 16'h0000};  // ADD r2,r5
        vecs[1] = '{16'h0178, ALU, 2'b11, 0, 16'h0000};  // op101 r7,r0
        vecs[2] = '{16'h00CB, MV,  2'b00, 0, 16'h0000};  // MV r1,r3
        vecs[3] = '{16'h01A0, MVI, 2'b00, 3, 16'hBEEF};  // MVI r4, 3 waits
        vecs[4] = '{16'h0047, ALU, 2'b01, 0, 16'h0000};  // op001 r0,r7
        vecs[5] = '{16'h009B, ALU, 2'b10, 0, 16'h0000};  // op010 r3,r3
        vecs[6] = '{16'h0131, ALU, 2'b11, 0, 16'h0000};  // op100 r6,r1
        vecs[7] = '{16'h01EA, ALU, 2'b11, 0, 16'h0000};  // op111 r5,r2
        vecs[8] = '{16'hFFB8, MVI, 2'b00, 0, 16'h1234};  // MVI r7, upper bits junk
        vecs[9] = '{16'h00C7, MV,  2'b00, 0, 16'h0000};  // MV r0,r7

        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs", 64'(sample1()), 64'd0);
        chk("reset_outputs_6", 64'({d2_busy, d2_done, d2_err, d2_opSelect, d2_immSelect,
            d2_immData, d2_regRSelect, d2_regAEnable, d2_regREnable, d2_regSelect, d2_regEnable}), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset asserted while in EXEC of an opSelect=11 instruction.
        run = 1'b1; inn = 16'h0178;
        @(posedge clock); #1; run = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("pre_reset_exec", {62'd0, regREnable, opSelect[0]}, 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outputs", 64'(sample1()), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        m_op = 2'b00; m_imm = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            chk("no_done_after_reset", {62'd0, busy, done}, 64'd0);
        end
        run_vec(vecs[2]);
        run_vec(vecs[0]);

        // Six-register instance: out-of-range fields.
        run2 = 1'b1; inn2 = 16'h0031;            // ADD r6,r1
        @(posedge clock); #1; run2 = 1'b0;
        chk("d6_add_decode", {61'd0, d2_busy, d2_done, d2_err}, 64'h4);
        @(posedge clock); #1;
        chk("d6_add_err_done", {61'd0, d2_busy, d2_done, d2_err}, 64'h7);
        @(posedge clock); #1;
        chk("d6_add_idle", {61'd0, d2_busy, d2_done, d2_err}, 64'h0);
        run2 = 1'b1; inn2 = 16'h00CE;            // MV r1,r6
        @(posedge clock); #1; run2 = 1'b0;
        @(posedge clock); #1;
        chk("d6_mv_err_done", {61'd0, d2_busy, d2_done, d2_err}, 64'h7);
        @(posedge clock); #1;
        chk("d6_no_write_on_err", {63'd0, bad6_seen}, 64'd0);
        mon6_on = 1'b0;
        run2 = 1'b1; inn2 = 16'h0197;            // MVI r2, ry=7 unused
        @(posedge clock); #1; run2 = 1'b0;
        @(posedge clock); #1; run2 = 1'b1; inn2 = 16'h5A5A;
        @(posedge clock); #1; run2 = 1'b0;
        chk("d6_mvi_write", {40'd0, d2_immSelect, d2_immData, d2_regSelect, d2_regEnable},
            {40'd0, 1'b1, 16'h5A5A, 6'd0, 6'b000100});
        @(posedge clock); #1;
        chk("d6_mvi_done", {61'd0, d2_busy, d2_done, d2_err}, 64'h6);

        repeat (3) @(posedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
